// File: rtl/uart_cmd_parser.sv
// 14-byte UART command framer: header, 11 payload bytes, CRC-8, footer -> one decoded command strobe.
// Define UART_CMD_CRC_CHK_EN to build and check the CRC-8; otherwise the CRC byte is ignored.
module uart_cmd_parser #(
   parameter int unsigned TIMEOUT_CYC = 43400,
   parameter logic [7:0]  HDR_BYTE    = 8'h55,
   parameter logic [7:0]  FTR_BYTE    = 8'hAA
) (
   input  logic        sys_clk,
   input  logic        sys_rst,
   input  logic        rx_done,
   input  logic [7:0]  rx_data,
   output logic        cmd_valid,
   output logic [7:0]  cmd_func,
   output logic [7:0]  cmd_ch,
   output logic [7:0]  cmd_sta,
   output logic [7:0]  cmd_duty,
   output logic [15:0] cmd_dessert,
   output logic [7:0]  cmd_pulse_num,
   output logic [31:0] cmd_pat,
   output logic        crc_err,
   output logic        frame_err,
   output logic        busy
);

   localparam int TW = $clog2(TIMEOUT_CYC + 1);

   typedef enum logic [1:0] {HUNT, PAYLOAD, CHK, FOOTER} state_t;

   state_t        state_q;
   logic [TW-1:0] tmr_q;
   logic [3:0]    idx_q;
   logic [87:0]   sh_q;   // byte 1 ends up in [87:80], byte 11 in [7:0]
   logic          tmo;

   // A byte arriving in the expiry cycle takes priority over the timeout.
   assign tmo  = (state_q != HUNT) && !rx_done && (tmr_q == TW'(TIMEOUT_CYC));
   assign busy = (state_q != HUNT);

`ifdef UART_CMD_CRC_CHK_EN
   logic [7:0] crc_q, crc_d;
   logic       crc_ok_q;

   always_comb begin
      crc_d = crc_q ^ rx_data;
      for (int i = 0; i < 8; i++)
         crc_d = crc_d[7] ? ({crc_d[6:0], 1'b0} ^ 8'h07) : {crc_d[6:0], 1'b0};
   end
`else
   assign crc_err = 1'b0;
`endif

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         state_q       <= HUNT;
         tmr_q         <= '0;
         idx_q         <= '0;
         sh_q          <= '0;
         cmd_valid     <= 1'b0;
         frame_err     <= 1'b0;
         cmd_func      <= '0;
         cmd_ch        <= '0;
         cmd_sta       <= '0;
         cmd_duty      <= '0;
         cmd_dessert   <= '0;
         cmd_pulse_num <= '0;
         cmd_pat       <= '0;
`ifdef UART_CMD_CRC_CHK_EN
         crc_q         <= '0;
         crc_ok_q      <= 1'b0;
         crc_err       <= 1'b0;
`endif
      end else begin
         cmd_valid <= 1'b0;
         frame_err <= 1'b0;
`ifdef UART_CMD_CRC_CHK_EN
         crc_err   <= 1'b0;
`endif
         tmr_q <= (rx_done || state_q == HUNT) ? '0 : tmr_q + 1'b1;
         if (tmo) begin
            frame_err <= 1'b1;
            state_q   <= HUNT;
            sh_q      <= '0;
            tmr_q     <= '0;
         end else if (rx_done) begin
            case (state_q)
               HUNT: begin
                  if (rx_data == HDR_BYTE) begin
                     state_q <= PAYLOAD;
                     idx_q   <= '0;
`ifdef UART_CMD_CRC_CHK_EN
                     crc_q   <= '0;
`endif
                  end
               end
               PAYLOAD: begin
                  sh_q  <= {sh_q[79:0], rx_data};
                  idx_q <= idx_q + 4'd1;
`ifdef UART_CMD_CRC_CHK_EN
                  crc_q <= crc_d;
`endif
                  if (idx_q == 4'd10) state_q <= CHK;
               end
               CHK: begin
`ifdef UART_CMD_CRC_CHK_EN
                  crc_ok_q <= (rx_data == crc_q);
`endif
                  state_q <= FOOTER;
               end
               FOOTER: begin
                  state_q <= HUNT;
                  if (rx_data != FTR_BYTE)
                     frame_err <= 1'b1;
`ifdef UART_CMD_CRC_CHK_EN
                  else if (!crc_ok_q)
                     crc_err <= 1'b1;
`endif
                  else begin
                     cmd_valid     <= 1'b1;
                     cmd_func      <= sh_q[87:80];
                     cmd_ch        <= sh_q[79:72];
                     cmd_sta       <= sh_q[71:64];
                     cmd_duty      <= sh_q[63:56];
                     cmd_dessert   <= sh_q[55:40];
                     cmd_pulse_num <= sh_q[39:32];
                     cmd_pat       <= sh_q[31:0];
                  end
               end
               default: state_q <= HUNT;
            endcase
         end
      end
   end

endmodule
